seq_alu: RTL

Multi-cycle execution unit that consumes the 3-bit ALU operation code produced by the ALU control decoder. It executes that code on two operands.
- Single-cycle ops: ADD, SUB, AND, OR, SLT.
- Iterative ops: MUL (shift-add) and DIV (restoring, unsigned).
- Sits in the execute stage of the processor. Uses a start/ready/done handshake so the control path can stall on MUL/DIV.

---
 rtl/seq_alu_pkg.sv | 23 ++
 rtl/seq_alu_iter.sv | 69 ++++++
 rtl/seq_alu.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/seq_alu_pkg.sv
// Shared encodings for the sequential ALU and the ALU control decoder.
// Build option: SEQ_ALU_HI_EN exposes the upper product / remainder as result_hi.
package seq_alu_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_MUL = 3'b010;
  localparam logic [2:0] ALU_DIV = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;
  localparam logic [2:0] ALU_OR  = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam logic [2:0] ALU_ILL = 3'b111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Ops that need the iterative datapath; divide-by-zero short-circuits.
  function automatic logic is_iter_op(input logic [2:0] op, input logic b_zero);
    return (op == ALU_MUL) || ((op == ALU_DIV) && !b_zero);
  endfunction

endpackage

// File: rtl/seq_alu_iter.sv
// Shared shift-add multiply / restoring unsigned divide datapath, one step per enable.
// Build option: SEQ_ALU_HI_EN exports the accumulator (upper product / remainder).
module seq_alu_iter
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             mode_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SEQ_ALU_HI_EN
  output logic [WIDTH-1:0] acc_nxt_c,
`endif
  output logic [WIDTH-1:0] lo_nxt_c
);

  logic [WIDTH-1:0] acc, lo, m;
  logic [WIDTH-1:0] acc_nxt, lo_nxt;
  logic [WIDTH:0]   sum, rem_sh, diff;

  // MUL: {acc,lo} shifts right with conditional add. DIV: {acc,lo} shifts left with trial subtract.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, m};
    rem_sh  = {acc, lo[WIDTH-1]};
    diff    = rem_sh - {1'b0, m};
    acc_nxt = acc;
    lo_nxt  = lo;
    if (mode_div) begin
      if (!diff[WIDTH]) begin
        acc_nxt = diff[WIDTH-1:0];
        lo_nxt  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = rem_sh[WIDTH-1:0];
        lo_nxt  = {lo[WIDTH-2:0], 1'b0};
      end
    end else if (lo[0]) begin
      acc_nxt = sum[WIDTH:1];
      lo_nxt  = {sum[0], lo[WIDTH-1:1]};
    end else begin
      acc_nxt = {1'b0, acc[WIDTH-1:1]};
      lo_nxt  = {acc[0], lo[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      lo  <= '0;
      m   <= '0;
    end else if (load) begin
      acc <= '0;
      lo  <= a;
      m   <= b;
    end else if (step) begin
      acc <= acc_nxt;
      lo  <= lo_nxt;
    end
  end

  assign lo_nxt_c = lo_nxt;
`ifdef SEQ_ALU_HI_EN
  assign acc_nxt_c = acc_nxt;
`endif

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle execute-stage ALU with start/ready/done handshake.
// Build option: SEQ_ALU_HI_EN adds result_hi (upper product / remainder).
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       aluop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_by_zero,
  output logic             illegal
`ifdef SEQ_ALU_HI_EN
  ,
  output logic [WIDTH-1:0] result_hi
`endif
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  logic [1:0]       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       op_q, op_nxt;
  logic [WIDTH-1:0] result_nxt;
  logic             zero_nxt, dbz_nxt, ill_nxt;
  logic             load_c, step_c, mode_div_c;
  logic [WIDTH-1:0] lo_nxt_c;
`ifdef SEQ_ALU_HI_EN
  logic [WIDTH-1:0] acc_nxt_c;
  logic [WIDTH-1:0] hi_nxt;
`endif

  assign mode_div_c = (op_q == ALU_DIV);

  seq_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (load_c),
    .step     (step_c),
    .mode_div (mode_div_c),
    .a        (a),
    .b        (b),
`ifdef SEQ_ALU_HI_EN
    .acc_nxt_c(acc_nxt_c),
`endif
    .lo_nxt_c (lo_nxt_c)
  );

  // Next state, counter and result/flag values; results change only on DONE entry.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    op_nxt     = op_q;
    result_nxt = result;
    dbz_nxt    = div_by_zero;
    ill_nxt    = illegal;
    load_c     = 1'b0;
    step_c     = 1'b0;
`ifdef SEQ_ALU_HI_EN
    hi_nxt     = result_hi;
`endif
    case (state)
      S_IDLE: begin
        if (start && ready) begin
          op_nxt = aluop;
          if (is_iter_op(aluop, b == '0)) begin
            load_c    = 1'b1;
            cnt_nxt   = CNT_W'(WIDTH);
            state_nxt = S_BUSY;
          end else begin
            state_nxt = S_DONE;
            dbz_nxt   = 1'b0;
            ill_nxt   = 1'b0;
`ifdef SEQ_ALU_HI_EN
            hi_nxt    = '0;
`endif
            case (aluop)
              ALU_ADD: result_nxt = a + b;
              ALU_SUB: result_nxt = a - b;
              ALU_AND: result_nxt = a & b;
              ALU_OR:  result_nxt = a | b;
              ALU_SLT: result_nxt = WIDTH'($signed(a) < $signed(b));
              ALU_DIV: begin
                result_nxt = '1;
                dbz_nxt    = 1'b1;
`ifdef SEQ_ALU_HI_EN
                hi_nxt     = a;
`endif
              end
              default: begin
                result_nxt = '0;
                ill_nxt    = 1'b1;
              end
            endcase
          end
        end
      end
      S_BUSY: begin
        step_c  = 1'b1;
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt  = S_DONE;
          result_nxt = lo_nxt_c;
          dbz_nxt    = 1'b0;
          ill_nxt    = 1'b0;
`ifdef SEQ_ALU_HI_EN
          hi_nxt     = acc_nxt_c;
`endif
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    zero_nxt = (result_nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= ALU_ADD;
      ready       <= 1'b1;
      done        <= 1'b0;
      result      <= '0;
      zero        <= 1'b1;
      div_by_zero <= 1'b0;
      illegal     <= 1'b0;
`ifdef SEQ_ALU_HI_EN
      result_hi   <= '0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      op_q        <= op_nxt;
      ready       <= (state_nxt == S_IDLE);
      done        <= (state_nxt == S_DONE);
      result      <= result_nxt;
      zero        <= zero_nxt;
      div_by_zero <= dbz_nxt;
      illegal     <= ill_nxt;
`ifdef SEQ_ALU_HI_EN
      result_hi   <= hi_nxt;
`endif
    end
  end

endmodule
